// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer and the ALU decode.
// Holds the eight SELECT codes ({2'b01, funct3}) and the sequencer state encoding.
package muldiv_pkg;

  localparam logic [4:0] SelMul    = 5'b01000;
  localparam logic [4:0] SelMulh   = 5'b01001;
  localparam logic [4:0] SelMulhsu = 5'b01010;
  localparam logic [4:0] SelMulhu  = 5'b01011;
  localparam logic [4:0] SelDiv    = 5'b01100;
  localparam logic [4:0] SelDivu   = 5'b01101;
  localparam logic [4:0] SelRem    = 5'b01110;
  localparam logic [4:0] SelRemu   = 5'b01111;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin,
    StDone
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the mul/div sequencer.
//   start/select/data1/data2 : request, sampled by the sequencer in IDLE
//   kill                     : pipeline flush
//   busy/done/result         : status and registered result
interface muldiv_sequencer_if #(
  parameter int unsigned Width = 32
);
  logic             start;
  logic [4:0]       select;
  logic [Width-1:0] data1;
  logic [Width-1:0] data2;
  logic             kill;
  logic             busy;
  logic             done;
  logic [Width-1:0] result;

  modport master (
    output start, select, data1, data2, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, select, data1, data2, kill,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_core.sv
// Shift/add/subtract datapath shared by multiply and divide.
//   load      : acc <= 0, lo <= op_a, operand register <= op_b
//   step      : one radix-2 iteration (shift-add multiply or restoring divide)
//   is_div    : selects the divide step
//   acc/lo    : multiply -> {high, low} product; divide -> remainder / quotient
module muldiv_core #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [Width-1:0] op_a,
  input  logic [Width-1:0] op_b,
  output logic [Width-1:0] acc,
  output logic [Width-1:0] lo
);

  logic [Width-1:0] acc_q, acc_d, lo_q, lo_d, b_q, b_d;
  logic [Width:0]   mul_sum, trial, diff;
  logic             fits;

  always_comb begin
    mul_sum = {1'b0, acc_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    // Remainder shifted left with the next dividend bit, which sits at the top of lo.
    trial   = {acc_q, lo_q[Width-1]};
    fits    = trial >= {1'b0, b_q};
    diff    = trial - {1'b0, b_q};

    acc_d = acc_q;
    lo_d  = lo_q;
    b_d   = b_q;
    if (load) begin
      acc_d = '0;
      lo_d  = op_a;
      b_d   = op_b;
    end else if (step) begin
      if (is_div) begin
        // diff < divisor whenever fits, so it always fits in Width bits.
        acc_d = fits ? diff[Width-1:0] : trial[Width-1:0];
        lo_d  = {lo_q[Width-2:0], fits};
      end else begin
        acc_d = mul_sum[Width:1];
        lo_d  = {mul_sum[0], lo_q[Width-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
    end
  end

  assign acc = acc_q;
  assign lo  = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : request/response bundle (slave side); busy stalls the pipeline,
//           done pulses for one cycle with result valid
// Holds the FSM, iteration counter, sign bookkeeping and special-case detection;
// the iterative datapath lives in muldiv_core.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] result_q, result_d;
  logic             is_div_q, hi_q, neg_q, fast_q;
  logic [Width-1:0] fast_res_q;

  logic             accept, is_div_op, is_rem_op, a_signed, b_signed, neg_a, neg_b;
  logic             div_zero, ovf, fast_d, neg_d;
  logic [Width-1:0] fast_res_d, mag_a, mag_b;
  logic             core_load, core_step;
  logic [Width-1:0] core_acc, core_lo, div_raw, div_res, mul_res;
  logic [2*Width-1:0] prod, prod_fix;

  // Request decode and operand conditioning.
  always_comb begin
    accept    = (state_q == StIdle) && bus.start && !bus.kill && (bus.select[4:3] == 2'b01);
    is_div_op = bus.select[2];
    is_rem_op = bus.select[2] && bus.select[1];
    a_signed  = (bus.select == SelMulh) || (bus.select == SelMulhsu) ||
                (bus.select == SelDiv)  || (bus.select == SelRem);
    b_signed  = (bus.select == SelMulh) || (bus.select == SelDiv) || (bus.select == SelRem);
    neg_a     = a_signed && bus.data1[Width-1];
    neg_b     = b_signed && bus.data2[Width-1];
    mag_a     = neg_a ? ('0 - bus.data1) : bus.data1;
    mag_b     = neg_b ? ('0 - bus.data2) : bus.data2;
    neg_d     = is_rem_op ? neg_a : (neg_a ^ neg_b);

    div_zero  = is_div_op && (bus.data2 == '0);
    ovf       = ((bus.select == SelDiv) || (bus.select == SelRem)) &&
                (bus.data1 == MinNeg) && (bus.data2 == '1);
    fast_d    = div_zero || ovf;
    if (div_zero) fast_res_d = is_rem_op ? bus.data1 : '1;
    else          fast_res_d = is_rem_op ? '0 : MinNeg;
  end

  // Final sign correction and word selection.
  always_comb begin
    prod     = {core_acc, core_lo};
    prod_fix = neg_q ? ('0 - prod) : prod;
    mul_res  = hi_q ? prod_fix[2*Width-1:Width] : prod_fix[Width-1:0];
    div_raw  = hi_q ? core_acc : core_lo;
    div_res  = neg_q ? ('0 - div_raw) : div_raw;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (fast_d) begin
            state_d = StFin;
          end else begin
            state_d   = StCalc;
            cnt_d     = CntW'(Width - 1);
            core_load = 1'b1;
          end
        end
      end
      StCalc: begin
        if (bus.kill) begin
          state_d = StIdle;
        end else begin
          core_step = 1'b1;
          if (cnt_q == '0) state_d = StFin;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      StFin: begin
        if (bus.kill) begin
          state_d = StIdle;
        end else begin
          result_d = fast_q ? fast_res_q : (is_div_q ? div_res : mul_res);
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      result_q   <= '0;
      is_div_q   <= 1'b0;
      hi_q       <= 1'b0;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      if (accept) begin
        is_div_q   <= is_div_op;
        // High word for MULH*, remainder for REM*.
        hi_q       <= is_div_op ? bus.select[1] : (bus.select[1:0] != 2'b00);
        neg_q      <= neg_d;
        fast_q     <= fast_d;
        fast_res_q <= fast_res_d;
      end
    end
  end

  muldiv_core #(
    .Width (Width)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_div_q),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .acc    (core_acc),
    .lo     (core_lo)
  );

  assign bus.busy   = (state_q != StIdle);
  // A kill in DONE suppresses the pulse; result_q itself is left intact.
  assign bus.done   = (state_q == StDone) && !bus.kill;
  assign bus.result = result_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multi-cycle controller and datapath for the RV32M operations in the EX stage. It accepts one multiply/divide request at a time, runs a radix-2 shift-add (multiply) or restoring (divide) loop, and holds BUSY high so the pipeline hazard unit stalls. It returns a registered 32-bit RESULT with a one-cycle DONE pulse. It replaces single-cycle combinational mul/div paths so the FPGA build can meet timing.

## Interface
- WIDTH, 32: operand/result width; the iteration count equals WIDTH.
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- START  input  1  request strobe, sampled only in IDLE.
- SELECT  input  5  operation code; 5'b01 followed by RV32M funct3.
- DATA1  input  WIDTH  rs1 operand, captured on accepted START.
- DATA2  input  WIDTH  rs2 operand, captured on accepted START.
- KILL  input  1  pipeline flush; aborts the operation in flight.
- BUSY  output  1  high from the cycle after acceptance until DONE, inclusive.
- DONE  output  1  one-cycle pulse; RESULT is valid.
- RESULT  output  WIDTH  registered result; held until the next accepted START.

## Operation
- SELECT codes:
  - 01000 MUL: low word.
  - 01001 MULH: signed×signed, high word.
  - 01010 MULHSU: signed DATA1 × unsigned DATA2, high word.
  - 01011 MULHU: high word.
  - 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
- Acceptance: START=1 while in IDLE, with SELECT[4:3]==2'b01. Any other SELECT value is ignored; there is no state change.
- Operand capture: signed operands are converted to magnitude. The result sign is recorded:
  - mul: XOR of the operand signs.
  - DIV: XOR of the operand signs.
  - REM: sign of the dividend.
- States:
  - IDLE: accept. Go to CALC. If it is a divide with DATA2==0, or a signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF, DIV/REM), go to FIN directly.
  - CALC: WIDTH iterations. A counter runs WIDTH-1 down to 0. Leave for FIN when the counter is 0.
  - FIN: apply the sign correction, select the low/high word or quotient/remainder, and write RESULT. Go to DONE.
  - DONE: DONE=1 for one cycle. Return to IDLE.
- Multiply: 2×WIDTH product register. Each iteration adds the multiplicand if the LSB is 1, then shifts right.
- Divide: restoring. Shift the remainder left with the next dividend bit. Subtract the divisor if the remainder ≥ divisor, and set the quotient bit.
- Special results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- KILL:
  - In CALC, FIN or DONE: next state is IDLE, with no DONE pulse. RESULT is not updated; if KILL arrives in DONE, RESULT stays valid.
  - KILL takes priority over START in the same cycle. A START in IDLE with KILL=1 is not accepted.
- START while not in IDLE is ignored. The upstream stage holds the request while BUSY=1.

## Timing
- Reset values: state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0.
- START is accepted at edge 0. BUSY=1 from cycle 1.
- Normal latency:
  - CALC occupies cycles 1..WIDTH.
  - FIN is cycle WIDTH+1.
  - DONE=1 in cycle WIDTH+2, which is cycle 34 for WIDTH=32.
- Fast path (divide by zero, overflow): FIN in cycle 1, DONE in cycle 2.
- BUSY deasserts in the cycle after DONE. The earliest next acceptance is the cycle after DONE, when the block is back in IDLE.
- RESET asserted mid-operation returns all outputs to their reset values at the next edge.

## Structure
- Shared package muldiv_pkg holds:
  - localparams for the 8 SELECT codes;
  - the state encoding: IDLE, CALC, FIN, DONE.
- The ALU decode uses the same package, so its constants never diverge.
- One sub-module, muldiv_core, holds the shift/add/subtract datapath registers and the per-iteration step.
- The top level holds the FSM, the counter, sign bookkeeping and the special-case detection.

## Test plan
- MUL 7×6: START, then RESULT=0x0000002A, DONE at cycle 34, BUSY high for cycles 1..34.
- MULH 0xFFFFFFFF×0xFFFFFFFF gives 0x00000000. MULHU on the same operands gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 gives 0xFFFFFFFF.
- DIV −7/2 gives 0xFFFFFFFD. REM −7/2 gives 0xFFFFFFFF. DIVU 100/7 gives 14. REMU 100/7 gives 2.
- DIVU 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5, each with DONE at cycle 2. DIV 0x80000000/0xFFFFFFFF gives 0x80000000, with DONE at cycle 2.
- KILL at cycle 10 of a DIV: IDLE at cycle 11, no DONE, RESULT unchanged. A START in the same cycle as KILL is not accepted.
- RESET at cycle 15 of a MUL gives BUSY=0, RESULT=0 the next cycle. A START 2 cycles later completes normally. A START pulse during BUSY is ignored.
